cache_tag_array_assoc: RTL

- Parametrised N-way set-associative tag store; successor to the single-way direct-mapped tag memory.
- Holds tag and valid bits per set/way and does a 1-cycle registered lookup returning hit, hit way and replacement victim.
- Accepts fills from the miss handler and runs an invalidate-all sweep.
- Sits between the cache controller and the data arrays; hit_way/victim_way select the data-array way.

---
 rtl/cache_tag_array_assoc.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cache_tag_array_assoc.sv
// N-way set-associative tag store with a registered 1-cycle lookup, round-robin
// victim selection, miss-handler fills and a one-set-per-cycle invalidate-all sweep.
module cache_tag_array_assoc #(
  parameter int SET_BITS = 3,
  parameter int TAG_BITS = 14,
  parameter int WAYS     = 2,
  parameter int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                lookup_valid,
  input  logic [SET_BITS-1:0] lookup_set,
  input  logic [TAG_BITS-1:0] lookup_tag,
  output logic                lookup_ready,
  output logic                resp_valid,
  output logic                hit,
  output logic [WAY_BITS-1:0] hit_way,
  output logic [WAY_BITS-1:0] victim_way,
  input  logic                fill_enable,
  input  logic [SET_BITS-1:0] fill_set,
  input  logic [WAY_BITS-1:0] fill_way,
  input  logic [TAG_BITS-1:0] fill_tag,
  input  logic                inv_all_req,
  output logic                busy
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Lowest set bit of a way vector; zero when the vector is empty.
  function automatic logic [WAY_BITS-1:0] first_one(input logic [WAYS-1:0] vec);
    logic [WAY_BITS-1:0] idx;
    idx = {WAY_BITS{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vec[w]) begin
        idx = WAY_BITS'(w);
      end
    end
    return idx;
  endfunction

  logic [TAG_BITS-1:0] tag_mem_r [SETS][WAYS];
  logic [WAYS-1:0]     valid_r   [SETS];
  logic [WAY_BITS-1:0] rr_ptr_r  [SETS];

  state_t              state_r;
  state_t              state_next_s;
  logic [SET_BITS-1:0] sweep_set_r;
  logic                busy_s;

  logic [WAYS-1:0]     match_s;
  logic [WAYS-1:0]     set_valid_s;
  logic                hit_s;
  logic [WAY_BITS-1:0] hit_way_s;
  logic [WAY_BITS-1:0] victim_s;
  logic                lookup_accept_s;
  logic                fill_way_ok_s;
  logic                fill_fire_s;
  logic [WAY_BITS-1:0] fill_rr_next_s;

  logic                resp_valid_r;
  logic                hit_r;
  logic [WAY_BITS-1:0] hit_way_r;
  logic [WAY_BITS-1:0] victim_r;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: a sweep ends after the last set has been cleared.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (inv_all_req) begin
          state_next_s = ST_SWEEP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (sweep_set_r == SET_BITS'(SETS - 1)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SWEEP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s = 1'b0;
    case (state_r)
      ST_IDLE:  busy_s = 1'b0;
      ST_SWEEP: busy_s = 1'b1;
      default:  busy_s = 1'b0;
    endcase
  end

  assign busy         = busy_s;
  assign lookup_ready = ~busy_s;

  // Sweep set counter; wraps back to zero as the sweep finishes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sweep_set_r <= {SET_BITS{1'b0}};
    end else if (state_r == ST_SWEEP) begin
      sweep_set_r <= sweep_set_r + SET_BITS'(1);
    end else begin
      sweep_set_r <= {SET_BITS{1'b0}};
    end
  end

  // Tag compare and victim choice against pre-edge array contents.
  always_comb begin
    set_valid_s = valid_r[lookup_set];
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = set_valid_s[w] && (tag_mem_r[lookup_set][w] == lookup_tag);
    end
    hit_s     = |match_s;
    hit_way_s = first_one(match_s);
    if (&set_valid_s) begin
      victim_s = rr_ptr_r[lookup_set];
    end else begin
      victim_s = first_one(~set_valid_s);
    end
  end

  assign lookup_accept_s = lookup_valid & ~busy_s;
  assign fill_way_ok_s   = (int'(fill_way) < WAYS);
  assign fill_fire_s     = fill_enable & ~busy_s & fill_way_ok_s;
  assign fill_rr_next_s  = (fill_way == WAY_BITS'(WAYS - 1)) ? {WAY_BITS{1'b0}}
                                                              : fill_way + WAY_BITS'(1);

  // Tag storage needs no reset: valid bits gate every use.
  always_ff @(posedge clock) begin
    if (fill_fire_s) begin
      tag_mem_r[fill_set][fill_way] <= fill_tag;
    end
  end

  // Valid bits and round-robin pointers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s]  <= {WAYS{1'b0}};
        rr_ptr_r[s] <= {WAY_BITS{1'b0}};
      end
    end else if (state_r == ST_SWEEP) begin
      valid_r[sweep_set_r]  <= {WAYS{1'b0}};
      rr_ptr_r[sweep_set_r] <= {WAY_BITS{1'b0}};
    end else if (fill_fire_s) begin
      valid_r[fill_set][fill_way] <= 1'b1;
      rr_ptr_r[fill_set]          <= fill_rr_next_s;
    end
  end

  // Response registers; result fields hold when no lookup is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_r <= 1'b0;
      hit_r        <= 1'b0;
      hit_way_r    <= {WAY_BITS{1'b0}};
      victim_r     <= {WAY_BITS{1'b0}};
    end else begin
      resp_valid_r <= lookup_accept_s;
      if (lookup_accept_s) begin
        hit_r     <= hit_s;
        hit_way_r <= hit_way_s;
        victim_r  <= victim_s;
      end
    end
  end

  assign resp_valid = resp_valid_r;
  assign hit        = hit_r;
  assign hit_way    = hit_way_r;
  assign victim_way = victim_r;

endmodule
